lelo_temp_seq: RTL

Sequenced, parametrised temperature-oscillator measurement block. It runs in the 32768 Hz real-time-clock domain and owns the oscillator enable. It samples a Gray-coded free-running oscillator edge counter through a synchroniser and produces contiguous per-window edge-count deltas. It also produces a 2^AVG_LOG2-sample average, saturation and threshold-alarm flags, in single-burst or continuous mode. It sits between the analog oscillator macro (with its Gray counter) and the digital readout logic.

---
 rtl/lelo_temp_pkg.sv | 32 +++
 rtl/lelo_gray_sync.sv | 31 +++
 rtl/lelo_temp_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lelo_temp_pkg.sv
// Shared types, constants and helpers for the temperature-oscillator sequencer.
package lelo_temp_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WINDOW = 2'd2
    } state_t;

    // The synchroniser needs a couple of cycles to deliver a clean baseline,
    // so the settle phase is never shorter than this.
    localparam int MIN_SETTLE = 3;

    // Width of the win_cycles input.
    localparam int WIN_W = 8;

    // Widest Gray code the helper below accepts.
    localparam int G2B_MAX_W = 32;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
    // Zero-extended narrower codes convert correctly because the upper bits are 0.
    function automatic logic [G2B_MAX_W-1:0] gray2bin(input logic [G2B_MAX_W-1:0] g);
        logic [G2B_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < G2B_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/lelo_gray_sync.sv
// Two-flop synchroniser for the oscillator-domain Gray counter, followed by
// Gray-to-binary conversion. Only one bit of a Gray code changes per step, so
// a bit caught mid-transition resolves to either the old or the new value.
module lelo_gray_sync
    import lelo_temp_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          lf_clk,
    input  logic          rst_n,
    input  logic [CW-1:0] gray_async,
    output logic [CW-1:0] bin_sync
);

    logic [CW-1:0] meta_reg;
    logic [CW-1:0] sync_reg;

    // Two-stage capture of the asynchronous Gray count.
    always_ff @(posedge lf_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= gray_async;
            sync_reg <= meta_reg;
        end
    end

    assign bin_sync = CW'(gray2bin(G2B_MAX_W'(sync_reg)));

endmodule

// File: rtl/lelo_temp_seq.sv
// Temperature-oscillator measurement sequencer. Enables the oscillator, waits
// for it to settle, then measures contiguous windows of W lf_clk cycles by
// differencing the synchronised edge counter. Each burst of 2^AVG_LOG2 windows
// is averaged and compared against an alarm threshold; continuous mode chains
// bursts without re-settling.
module lelo_temp_seq
    import lelo_temp_pkg::*;
#(
    parameter int CW       = 12,
    parameter int DW       = 8,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 4
) (
    input  logic             lf_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic [WIN_W-1:0] win_cycles,
    input  logic [DW-1:0]    thr,
    input  logic [CW-1:0]    ana_cnt_gray,
    output logic             ana_en,
    output logic             busy,
    output logic [DW-1:0]    delta,
    output logic             delta_valid,
    output logic [DW-1:0]    avg,
    output logic             avg_valid,
    output logic             ovf,
    output logic             alarm
);

    // A too-small SETTLE is clamped up rather than producing a bad baseline.
    localparam int SETTLE_EFF = (SETTLE < MIN_SETTLE) ? MIN_SETTLE : SETTLE;
    localparam int SCW        = $clog2(SETTLE_EFF);
    localparam int AW         = DW + AVG_LOG2;
    localparam int NWIN       = 1 << AVG_LOG2;
    localparam int IW         = AVG_LOG2 + 1;

    state_t state_reg;
    state_t state_next;

    logic [SCW-1:0]   settle_cnt_reg;
    logic [WIN_W-1:0] win_cnt_reg;
    logic [WIN_W-1:0] win_len_reg;
    logic [IW-1:0]    win_idx_reg;
    logic [CW-1:0]    base_reg;
    logic [AW-1:0]    acc_reg;

    logic [DW-1:0]    delta_reg;
    logic             delta_valid_reg;
    logic [DW-1:0]    avg_reg;
    logic             avg_valid_reg;
    logic             ovf_reg;
    logic             alarm_reg;

    logic [CW-1:0]    cnt_bin;
    logic [CW-1:0]    raw;
    logic             raw_over;
    logic [DW-1:0]    delta_sat;
    logic [AW-1:0]    sum_next;
    logic [DW-1:0]    avg_calc;
    logic [WIN_W-1:0] win_len_eff;
    logic             start_ok;
    logic             settle_done;
    logic             win_done;
    logic             burst_done;

    lelo_gray_sync #(
        .CW (CW)
    ) u_sync (
        .lf_clk     (lf_clk),
        .rst_n      (rst_n),
        .gray_async (ana_cnt_gray),
        .bin_sync   (cnt_bin)
    );

    // Phase-end conditions.
    assign start_ok    = (state_reg == ST_IDLE) && start;
    assign settle_done = (state_reg == ST_SETTLE) && (settle_cnt_reg == SCW'(SETTLE_EFF - 1));
    assign win_done    = (state_reg == ST_WINDOW) && (win_cnt_reg == win_len_reg - WIN_W'(1));
    assign burst_done  = win_done && (win_idx_reg == IW'(NWIN - 1));

    // A zero window length would never terminate; treat it as one cycle.
    assign win_len_eff = (win_cycles == '0) ? WIN_W'(1) : win_cycles;

    // Modular difference absorbs counter wrap; the synchroniser lag is the
    // same at both ends of a window so it cancels.
    assign raw = cnt_bin - base_reg;

    generate
        if (CW > DW) begin : g_sat
            assign raw_over = |raw[CW-1:DW];
        end else begin : g_nosat
            assign raw_over = 1'b0;
        end
    endgenerate

    assign delta_sat = raw_over ? {DW{1'b1}} : DW'(raw);
    assign sum_next  = acc_reg + AW'(delta_sat);
    assign avg_calc  = DW'(sum_next >> AVG_LOG2);

    // State register.
    always_ff @(posedge lf_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_next = ST_WINDOW;
                end
            end
            ST_WINDOW: begin
                if (burst_done && !cont) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs: the oscillator runs whenever the sequencer is active.
    always_comb begin
        ana_en = 1'b0;
        busy   = 1'b0;
        if (state_reg != ST_IDLE) begin
            ana_en = 1'b1;
            busy   = 1'b1;
        end
    end

    // Settle/window counters, baseline and burst accumulator.
    always_ff @(posedge lf_clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
            win_len_reg    <= WIN_W'(1);
            win_idx_reg    <= '0;
            base_reg       <= '0;
            acc_reg        <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        settle_cnt_reg <= '0;
                        win_idx_reg    <= '0;
                        acc_reg        <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg + SCW'(1);
                    if (settle_done) begin
                        base_reg    <= cnt_bin;
                        win_len_reg <= win_len_eff;
                        win_cnt_reg <= '0;
                    end
                end
                ST_WINDOW: begin
                    if (win_done) begin
                        // Next window starts on this same edge: no dead cycles.
                        base_reg    <= cnt_bin;
                        win_len_reg <= win_len_eff;
                        win_cnt_reg <= '0;
                        if (burst_done) begin
                            acc_reg     <= '0;
                            win_idx_reg <= '0;
                        end else begin
                            acc_reg     <= sum_next;
                            win_idx_reg <= win_idx_reg + IW'(1);
                        end
                    end else begin
                        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers, strobes and flags.
    always_ff @(posedge lf_clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_reg       <= '0;
            delta_valid_reg <= 1'b0;
            avg_reg         <= '0;
            avg_valid_reg   <= 1'b0;
            ovf_reg         <= 1'b0;
            alarm_reg       <= 1'b0;
        end else begin
            delta_valid_reg <= 1'b0;
            avg_valid_reg   <= 1'b0;
            if (start_ok) begin
                ovf_reg <= 1'b0;
            end
            if (win_done) begin
                delta_reg       <= delta_sat;
                delta_valid_reg <= 1'b1;
                if (raw_over) begin
                    ovf_reg <= 1'b1;
                end
                if (burst_done) begin
                    avg_reg       <= avg_calc;
                    avg_valid_reg <= 1'b1;
                    alarm_reg     <= (avg_calc > thr);
                end
            end
        end
    end

    assign delta       = delta_reg;
    assign delta_valid = delta_valid_reg;
    assign avg         = avg_reg;
    assign avg_valid   = avg_valid_reg;
    assign ovf         = ovf_reg;
    assign alarm       = alarm_reg;

endmodule
